alu_exec_unit: RTL and testbench

Multi-cycle ALU execution unit that consumes the 3-bit `aluop` code produced by the ALU-control decoder. It executes the operation on two latched operands and returns a registered result with zero and overflow flags. It sits in the execute stage, between the operand read path and writeback. A valid/ready handshake on both sides lets the iterative multiply stall the pipeline cleanly.

---
 rtl/alu_exec_unit.sv | 133 +++++++++++++
 tb/tb_alu_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU. Single-cycle logic/arith ops plus an
// iterative shift-add multiply. Valid/ready handshake on both sides;
// handshake outputs are decoded straight from the FSM state.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_NOR = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, mcand, mplr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] alu_res, sum, diff, acc_nx;
  logic             alu_ovf, accept, last;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(WIDTH - 1));

  assign sum    = a + b;
  assign diff   = a - b;
  // Accumulator value after this iteration: add the shifted multiplicand
  // when the current multiplier bit is set.
  assign acc_nx = acc + (mplr[0] ? mcand : '0);

  // Single-cycle op result and signed overflow (ADD/SUB only)
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluop)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: multiply detours through BUSY, everything else goes to DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (aluop == OP_MUL) ? BUSY : DONE;
      BUSY: if (last)   state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch single-cycle results on accept, step the multiplier
  // in BUSY, hold everything in DONE so outputs stay stable under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (aluop == OP_MUL) begin
            acc   <= '0;
            mcand <= a;
            mplr  <= b;
            cnt   <= '0;
          end else begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
          end
        end
        BUSY: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result   <= acc_nx;
            zero     <= (acc_nx == '0);
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed steps with a scoreboard queue; expected
// results are pushed when an op is issued and popped when out_valid rises.
module tb_alu_exec_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   aluop = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, overflow, busy;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model in plain integer arithmetic
  function automatic exp_t model(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, s;
    logic [31:0] p;
    sx = $signed(x);
    sy = $signed(y);
    e.tag = tag;
    e.ov  = 1'b0;
    e.res = '0;
    case (op)
      3'd0: begin s = sx + sy; e.res = s[W-1:0]; e.ov = (s > 32767) || (s < -32768); end
      3'd1: begin s = sx - sy; e.res = s[W-1:0]; e.ov = (s > 32767) || (s < -32768); end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: e.res = x ^ y;
      3'd5: e.res = (sx < sy) ? 16'd1 : 16'd0;
      3'd6: begin p = {16'h0, x} * {16'h0, y}; e.res = p[W-1:0]; end
      default: e.res = ~(x | y);
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Present one request; returns #1 after the accepting edge
  task automatic issue(input string tag, input logic [2:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    @(negedge clk);
    chk({tag, "_inready_pre"}, in_ready, 1);
    in_valid = 1'b1; aluop = op; a = x; b = y;
    if (push) sb.push_back(model(tag, op, x, y));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; aluop = 3'd3;
  endtask

  // Wait for out_valid, check latency (edges after accept), pop and compare,
  // hold out_ready low for 'hold' cycles, then transfer.
  task automatic collect(input int exp_lat, input int hold, input bit poke);
    int lat = 0, nbusy = 0;
    logic inr = 1'b0;
    exp_t e;
    while (!out_valid && lat < 100) begin
      nbusy += busy;
      inr |= in_ready;
      if (poke) in_valid = (lat == 3);
      if (poke && lat == 3) begin aluop = 3'd0; a = 16'h1111; b = 16'h2222; end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, exp_lat);
    chk("busy_cycles", nbusy, exp_lat);
    if (exp_lat > 0) chk("inready_during_busy", inr, 0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk({e.tag, "_valid"}, out_valid, 1);
      chk({e.tag, "_result"}, result, e.res);
      chk({e.tag, "_zero"}, zero, e.z);
      chk({e.tag, "_ovf"}, overflow, e.ov);
      chk({e.tag, "_inready_done"}, in_ready, 0);
      if (h < hold) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({e.tag, "_xfer_valid"}, out_valid, 0);
    chk({e.tag, "_xfer_inready"}, in_ready, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_inready"}, in_ready, 1);
    chk({tag, "_outvalid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_zero"}, zero, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int seen;
    // Reset asserted between edges: outputs must be at reset values at once
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk_reset_vals("rst_release");

    // ADD overflow, SUB to zero
    issue("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 1);
    collect(0, 0, 0);
    issue("sub_zero", 3'd1, 16'h0005, 16'h0005, 1);
    collect(0, 0, 0);
    issue("sub_ovf", 3'd1, 16'h8000, 16'h0001, 1);
    collect(0, 0, 0);

    // SLT, NOR, XOR, AND, OR
    issue("slt", 3'd5, 16'hFFFF, 16'h0001, 1);
    collect(0, 0, 0);
    issue("slt_false", 3'd5, 16'h0001, 16'hFFFF, 1);
    collect(0, 0, 0);
    issue("nor", 3'd7, 16'hFFFF, 16'h0001, 1);
    collect(0, 0, 0);
    issue("xor", 3'd4, 16'hF0F0, 16'hFF00, 1);
    collect(0, 0, 0);
    issue("and", 3'd2, 16'hF0F0, 16'hFF00, 1);
    collect(0, 0, 0);
    issue("or", 3'd3, 16'hF0F0, 16'h0F00, 1);
    collect(0, 0, 0);

    // MUL, with an in_valid pulse during BUSY that must be ignored
    issue("mul", 3'd6, 16'h0123, 16'h0010, 1);
    collect(W, 0, 1);
    issue("mul_ffff", 3'd6, 16'hFFFF, 16'hFFFF, 1);
    collect(W, 0, 0);
    issue("mul_mix", 3'd6, 16'h1234, 16'h00AB, 1);
    collect(W, 0, 0);

    // Backpressure: hold result for 3 cycles with out_ready low
    issue("add_bp", 3'd0, 16'h8000, 16'h8000, 1);
    collect(0, 3, 0);

    // Reset while in DONE: outputs clear immediately
    issue("add_pre_rst", 3'd0, 16'h1234, 16'h0001, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1 chk_reset_vals("rst_in_done");
    @(negedge clk) rst = 1'b0;

    // Reset mid-MUL: the aborted op never produces out_valid
    issue("mul_abort", 3'd6, 16'h0101, 16'h0101, 0);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("rst_mid_mul");
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      seen += out_valid;
    end
    chk("abort_no_outvalid", seen, 0);
    chk("abort_inready", in_ready, 1);
    issue("add_after_abort", 3'd0, 16'h0002, 16'h0003, 1);
    collect(0, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  // Absolute time bound so a stuck design still reaches a verdict
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
